// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO push arbiter.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_LOCKED = 2'd1,
        ARB_FLUSH  = 2'd2
    } arb_state_e;

    // Increment a requester index, wrapping back to 0 after n-1.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, with wrap.
module rr_pick #(
    parameter  int unsigned NUM_REQ  = 4,
    localparam int unsigned ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] rr_ptr,
    output logic                grant_valid,
    output logic [ID_WIDTH-1:0] grant_idx
);

    localparam logic [ID_WIDTH:0] NUM_REQ_W = (ID_WIDTH + 1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   rotated;
    logic [ID_WIDTH-1:0]  offset;
    logic [ID_WIDTH:0]    sum;

    // Bit k of rotated is the request k places after rr_ptr.
    assign req_dbl = {req, req};
    assign rotated = NUM_REQ'(req_dbl >> rr_ptr);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        grant_valid = 1'b0;
        offset      = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                grant_valid = 1'b1;
                offset      = ID_WIDTH'(k);
            end
        end
    end

    assign sum       = {1'b0, rr_ptr} + {1'b0, offset};
    assign grant_idx = (sum >= NUM_REQ_W) ? ID_WIDTH'(sum - NUM_REQ_W) : ID_WIDTH'(sum);

endmodule

// File: rtl/fifo_rr_push_arb.sv
// Round-robin push-side arbiter sharing one FIFO between producers; packets never
// interleave and flushes are deferred until the current packet is complete.
module fifo_rr_push_arb
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = 4,
    parameter  int unsigned DATA_WIDTH = 32,
    localparam int unsigned ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NUM_REQ-1:0]                  req_valid_i,
    input  logic [NUM_REQ-1:0]                  req_last_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data_i,
    output logic [NUM_REQ-1:0]                  req_ready_o,
    input  logic                                fifo_full_i,
    output logic                                fifo_push_o,
    output logic [ID_WIDTH+DATA_WIDTH:0]        fifo_data_o,
    input  logic                                flush_req_i,
    output logic                                flush_ack_o,
    output logic                                fifo_flush_o
);

    arb_state_e          state_q, state_d;
    logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0] owner_q, owner_d;
    logic                flush_pend_q, flush_pend_d;

    logic                pick_valid;
    logic [ID_WIDTH-1:0] pick_idx;
    logic                cand_valid;
    logic [ID_WIDTH-1:0] cand_idx;
    logic                push;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req         (req_valid_i),
        .rr_ptr      (rr_ptr_q),
        .grant_valid (pick_valid),
        .grant_idx   (pick_idx)
    );

    // Candidate grant: round-robin pick when idle, the lock owner otherwise.
    always_comb begin
        cand_valid = 1'b0;
        cand_idx   = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (!flush_req_i) begin
                    cand_valid = pick_valid;
                    cand_idx   = pick_idx;
                end
            end
            ARB_LOCKED: begin
                cand_valid = req_valid_i[owner_q];
                cand_idx   = owner_q;
            end
            default: ;
        endcase
    end

    // Outputs are gated by rst_ni so everything reads 0 while reset is asserted.
    assign push         = cand_valid & ~fifo_full_i & rst_ni;
    assign fifo_push_o  = push;
    assign fifo_flush_o = rst_ni & (state_q == ARB_FLUSH);
    assign flush_ack_o  = rst_ni & (state_q == ARB_FLUSH);
    assign fifo_data_o  = push ? {cand_idx, req_last_i[cand_idx], req_data_i[cand_idx]} : '0;

    always_comb begin
        req_ready_o = '0;
        if (push) begin
            req_ready_o[cand_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        flush_pend_d = flush_pend_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (flush_req_i) begin
                    state_d = ARB_FLUSH;
                end else if (push) begin
                    if (req_last_i[cand_idx]) begin
                        rr_ptr_d = ID_WIDTH'(rr_next(32'(cand_idx), NUM_REQ));
                    end else begin
                        owner_d = cand_idx;
                        state_d = ARB_LOCKED;
                    end
                end
            end
            ARB_LOCKED: begin
                if (flush_req_i) begin
                    flush_pend_d = 1'b1;
                end
                if (push && req_last_i[owner_q]) begin
                    rr_ptr_d = ID_WIDTH'(rr_next(32'(owner_q), NUM_REQ));
                    state_d  = (flush_pend_q || flush_req_i) ? ARB_FLUSH : ARB_IDLE;
                end
            end
            ARB_FLUSH: begin
                flush_pend_d = 1'b0;
                state_d      = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ARB_IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            flush_pend_q <= flush_pend_d;
        end
    end

endmodule

// File: doc/fifo_rr_push_arb.md
Name: fifo_rr_push_arb

Overview:
- Round-robin push-side arbiter that shares one fifo_v3 instance between NUM_REQ producers, e.g. the writeback/store/CP0 event sources feeding a shared queue in the MIPS core.
- Uses a valid/ready/last handshake per producer.
- Holds the grant for a whole multi-beat packet, so packets never interleave in the FIFO.
- Sequences FIFO flushes so a flush never lands in the middle of a packet.

Parameters:
- NUM_REQ, 4, number of producers (2..16).
- DATA_WIDTH, 32, payload width per beat.
- ID_WIDTH, (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1, source-tag width. Derived; do not override.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  NUM_REQ  per-producer beat valid.
- req_last_i  in  NUM_REQ  per-producer last beat of packet.
- req_data_i  in  NUM_REQ x DATA_WIDTH  per-producer payload.
- req_ready_o  out  NUM_REQ  beat accepted this cycle (one-hot or zero).
- fifo_full_i  in  1  from fifo full_o.
- fifo_push_o  out  1  to fifo push_i.
- fifo_data_o  out  ID_WIDTH+1+DATA_WIDTH  to fifo data_i, packed as {src_id, last, data}.
- flush_req_i  in  1  level request to flush the FIFO; held until ack.
- flush_ack_o  out  1  one-cycle flush completion pulse.
- fifo_flush_o  out  1  to fifo flush_i.

Behaviour:
- States: IDLE, LOCKED, FLUSH. Registers: state, rr_ptr (ID_WIDTH), owner (ID_WIDTH), flush_pend.
- Reset (async assert, sync release) sets state=IDLE, rr_ptr=0, owner=0, flush_pend=0.
- All outputs are combinational from state and inputs. During reset all outputs are 0.
- Zero latency: a beat is transferred in the same cycle its req_valid_i is seen.
- Transfer condition: fifo_push_o = grant_valid & ~fifo_full_i & (state != FLUSH).
  - req_ready_o[g] = fifo_push_o for the granted index g; all other bits are 0.
  - fifo_data_o = {g, req_last_i[g], req_data_i[g]}. It is don't-care when fifo_push_o=0; drive 0.
- IDLE with flush_req_i=1: go to FLUSH. No grant is issued this cycle.
- IDLE with flush_req_i=0:
  - g = first index with req_valid_i set, searching rr_ptr, rr_ptr+1, ... with wrap at NUM_REQ.
  - Transfer with last=1: rr_ptr <= (g == NUM_REQ-1) ? 0 : g+1. Stay IDLE.
  - Transfer with last=0: owner <= g, go to LOCKED. rr_ptr is unchanged.
- LOCKED:
  - Only owner is eligible; other requesters are ignored even if valid.
  - Owner valid=0 or FIFO full: no transfer, hold state.
  - Transfer with last=1: rr_ptr <= owner+1 (with wrap). Next state is FLUSH if flush_pend|flush_req_i, else IDLE.
  - flush_req_i seen in LOCKED sets flush_pend. The packet always completes first.
- FLUSH (exactly 1 cycle): fifo_flush_o=1, flush_ack_o=1, no push. Clear flush_pend, go to IDLE. rr_ptr is kept.
- Full FIFO: arbitration still computes g, but no beat moves and rr_ptr/state do not change. There is no fairness penalty for stalled requesters.
- Simultaneous flush_req_i and last-beat transfer in LOCKED: the beat is pushed, then FLUSH follows the next cycle.
- Protocol assertions (bench):
  - A requester must not drop valid or change data/last until ready.
  - flush_req_i must stay high until flush_ack_o.
- Async reset mid-packet discards the lock. The FIFO contents are the FIFO's own reset concern.

Decomposition:
- Package fifo_arb_pkg holds:
  - arb_state_e enum {ARB_IDLE, ARB_LOCKED, ARB_FLUSH};
  - a helper function rr_next(ptr, n) that increments with wrap.
- Sub-module rr_pick: purely combinational. Inputs req vector and rr_ptr; outputs grant_valid and grant_idx. Uses a doubled-vector priority search.
- The top module holds the FSM and the output muxing.

Test Plan:
- Single beat: NUM_REQ=4, rr_ptr=0, req_valid=0b1010, all last=1, FIFO not full → cycle 0 grants 1, rr_ptr=2; cycle 1 grants 3, rr_ptr=0; fifo_data_o src_id 1 then 3.
- Packet lock: req0 sends 3 beats (last on 3rd), req1 valid throughout → 3 consecutive src_id=0 beats, then req1 is granted. req_ready_o[1] stays 0 during the lock.
- Full stall: fifo_full_i=1 for 5 cycles mid-packet → fifo_push_o=0, state LOCKED, rr_ptr unchanged. Resumes the owner's next beat when full drops.
- Flush in IDLE: flush_req_i=1 with req2 valid → next cycle fifo_flush_o=flush_ack_o=1 for exactly one cycle, no push. req2 is granted the cycle after.
- Flush mid-packet: flush_req_i rises on beat 1 of a 4-beat packet → all 4 beats are pushed, FLUSH follows the cycle after the last beat, ack is a single pulse.
- Async reset: drop rst_ni mid-packet, off-clock-edge → outputs go to 0 immediately. After release, rr_ptr=0 and the lowest valid index wins.
